// File: rtl/arbiter_control_pkg.sv
// rtl/arbiter_control_pkg.sv - shared types and round-robin helper for the L1->L2 arbiter
package arbiter_control_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D,
        ARB_RELEASE
    } arb_state_t;

    typedef enum logic {
        ARB_OP_READ,
        ARB_OP_WRITE
    } arb_op_t;

    localparam logic ARB_SEL_I = 1'b0;
    localparam logic ARB_SEL_D = 1'b1;

    // On a tie the side that did not win last time gets the port.
    function automatic logic rr_pick(input logic req_i, input logic req_d, input logic last_grant);
        if (req_i && req_d) begin
            return ~last_grant;
        end
        return req_d ? ARB_SEL_D : ARB_SEL_I;
    endfunction

endpackage

// File: rtl/arbiter_control_if.sv
// rtl/arbiter_control_if.sv - L1I/L1D request, L2 command and response signal bundle
interface arbiter_control_if;

    logic L1I_read;
    logic L1D_read;
    logic L1D_write;
    logic L2_resp;
    logic arbiter_fsm_sel;
    logic L2_read;
    logic L2_write;
    logic L1I_resp;
    logic L1D_resp;

    modport slave (
        input  L1I_read,
        input  L1D_read,
        input  L1D_write,
        input  L2_resp,
        output arbiter_fsm_sel,
        output L2_read,
        output L2_write,
        output L1I_resp,
        output L1D_resp
    );

    modport master (
        output L1I_read,
        output L1D_read,
        output L1D_write,
        output L2_resp,
        input  arbiter_fsm_sel,
        input  L2_read,
        input  L2_write,
        input  L1I_resp,
        input  L1D_resp
    );

endinterface

// File: rtl/arbiter_stat_counter.sv
// rtl/arbiter_stat_counter.sv - saturating event counter with synchronous active-low reset
module arbiter_stat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/arbiter_control.sv
// rtl/arbiter_control.sv - L1I/L1D -> L2 grant FSM; ARBITER_STATS_EN adds grant/conflict counters
module arbiter_control
    import arbiter_control_pkg::*;
#(
    parameter int STAT_WIDTH = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    arbiter_control_if.slave  bus
`ifdef ARBITER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] i_grants,
    output logic [STAT_WIDTH-1:0] d_grants,
    output logic [STAT_WIDTH-1:0] conflicts
`endif
);

    arb_state_t state, state_next;
    arb_op_t    op, op_next;
    logic       last_grant, last_grant_next;
    logic       sel, sel_next;
    logic       req_i, req_d, grant_side;

    assign req_i      = bus.L1I_read;
    assign req_d      = bus.L1D_read | bus.L1D_write;
    assign grant_side = rr_pick(req_i, req_d, last_grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            op         <= ARB_OP_READ;
            last_grant <= ARB_SEL_D;
            sel        <= ARB_SEL_I;
        end else begin
            state      <= state_next;
            op         <= op_next;
            last_grant <= last_grant_next;
            sel        <= sel_next;
        end
    end

    always_comb begin
        state_next      = state;
        op_next         = op;
        last_grant_next = last_grant;
        sel_next        = sel;
        bus.L2_read     = 1'b0;
        bus.L2_write    = 1'b0;
        bus.L1I_resp    = 1'b0;
        bus.L1D_resp    = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (req_i || req_d) begin
                    last_grant_next = grant_side;
                    sel_next        = grant_side;
                    op_next         = (grant_side == ARB_SEL_D && bus.L1D_write) ? ARB_OP_WRITE
                                                                                 : ARB_OP_READ;
                    state_next      = (grant_side == ARB_SEL_D) ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                bus.L2_read  = (op == ARB_OP_READ);
                bus.L2_write = (op == ARB_OP_WRITE);
                bus.L1I_resp = bus.L2_resp;
                if (bus.L2_resp) begin
                    state_next = ARB_RELEASE;
                end
            end
            ARB_SERVE_D: begin
                bus.L2_read  = (op == ARB_OP_READ);
                bus.L2_write = (op == ARB_OP_WRITE);
                bus.L1D_resp = bus.L2_resp;
                if (bus.L2_resp) begin
                    state_next = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign bus.arbiter_fsm_sel = sel;

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.L1D_read && bus.L1D_write));

    a_resp_in_serve: assert property (@(posedge clk) disable iff (!rst_n)
        bus.L2_resp |-> (state == ARB_SERVE_I || state == ARB_SERVE_D));

`ifdef ARBITER_STATS_EN
    logic idle_grant, inc_i, inc_d, inc_conf;

    assign idle_grant = (state == ARB_IDLE) && (req_i || req_d);
    assign inc_i      = idle_grant && (grant_side == ARB_SEL_I);
    assign inc_d      = idle_grant && (grant_side == ARB_SEL_D);
    assign inc_conf   = (state == ARB_IDLE) && req_i && req_d;

    arbiter_stat_counter #(.WIDTH(STAT_WIDTH)) u_i_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_i),
        .count (i_grants)
    );

    arbiter_stat_counter #(.WIDTH(STAT_WIDTH)) u_d_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_d),
        .count (d_grants)
    );

    arbiter_stat_counter #(.WIDTH(STAT_WIDTH)) u_conflicts (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_conf),
        .count (conflicts)
    );
`endif

endmodule

// File: tb/tb_arbiter_control.sv
// tb/tb_arbiter_control.sv - randomized scoreboard bench for arbiter_control
module tb_arbiter_control;
    import arbiter_control_pkg::*;

    localparam int SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arbiter_control_if bus();

`ifdef ARBITER_STATS_EN
    logic [SW-1:0] i_grants, d_grants, conflicts;
`endif

    arbiter_control #(.STAT_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARBITER_STATS_EN
        ,
        .i_grants  (i_grants),
        .d_grants  (d_grants),
        .conflicts (conflicts)
`endif
    );

    typedef struct {
        int   cyc;
        logic side;
        logic wr;
    } grant_t;

    grant_t gq[$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    bit rst_req, rand_mode, hold_mode;
    bit i_act, d_act, d_wr, got_i, got_d;
    int fixed_lat;
    bit l2_busy;
    int l2_cnt;

    bit m_busy, m_last, m_side;
    int m_free, m_ig, m_dg, m_cf;

    int n_rd, n_wr, n_ir, n_dr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic int sat(input int v);
        return (v > (1 << SW) - 1) ? (1 << SW) - 1 : v;
    endfunction

    task automatic model_cycle();
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_free = cyc + 1;
            m_ig = 0; m_dg = 0; m_cf = 0;
        end else if (m_busy && bus.L2_resp) begin
            m_busy = 1'b0;
            m_free = cyc + 2;
            if (m_side) got_d = 1'b1;
            else got_i = 1'b1;
        end else if (!m_busy && cyc >= m_free && (i_act || d_act)) begin
            m_side = (i_act && d_act) ? !m_last : d_act;
            if (i_act && d_act) m_cf++;
            if (m_side) m_dg++;
            else m_ig++;
            m_last = m_side;
            m_busy = 1'b1;
            gq.push_back('{cyc + 1, m_side, m_side && d_wr});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = !rst_req;
        if (got_i) i_act = hold_mode;
        if (got_d) d_act = hold_mode;
        got_i = 1'b0;
        got_d = 1'b0;
        if (rand_mode) begin
            if (!i_act && $urandom_range(0, 2) == 0) i_act = 1'b1;
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1;
                d_wr  = 1'($urandom_range(0, 1));
            end
        end
        bus.L1I_read  = i_act;
        bus.L1D_read  = d_act && !d_wr;
        bus.L1D_write = d_act && d_wr;
        bus.L2_resp   = 1'b0;
        if (!rst_n) begin
            l2_busy = 1'b0;
        end else begin
            if ((bus.L2_read || bus.L2_write) && !l2_busy) begin
                l2_busy = 1'b1;
                l2_cnt  = rand_mode ? int'($urandom_range(0, 4)) : fixed_lat;
            end
            if (l2_busy) begin
                if (l2_cnt == 0) begin
                    bus.L2_resp = 1'b1;
                    l2_busy     = 1'b0;
                end else begin
                    l2_cnt--;
                end
            end
        end
        model_cycle();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        hold_mode = 1'b0;
        i_act = 1'b0;
        d_act = 1'b0;
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
        n_rd = 0; n_wr = 0; n_ir = 0; n_dr = 0;
    endtask

    always @(negedge clk) begin
        if (bus.L2_read)  n_rd++;
        if (bus.L2_write) n_wr++;
        if (bus.L1I_resp) n_ir++;
        if (bus.L1D_resp) n_dr++;
    end

    bit exp_on, exp_sel, exp_wr, rst_d;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_d) begin
                exp_on  = 1'b0;
                exp_sel = ARB_SEL_I;
            end
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                grant_t g;
                g       = gq.pop_front();
                exp_on  = 1'b1;
                exp_sel = g.side;
                exp_wr  = g.wr;
            end
            check("outs{rd,wr,sel,iresp,dresp}",
                  {27'd0, bus.L2_read, bus.L2_write, bus.arbiter_fsm_sel, bus.L1I_resp, bus.L1D_resp},
                  {27'd0, exp_on && !exp_wr, exp_on && exp_wr, exp_sel,
                   exp_on && bus.L2_resp && !exp_sel, exp_on && bus.L2_resp && exp_sel});
            if (exp_on && bus.L2_resp) exp_on = 1'b0;
            rst_d = rst_n;
        end
    end

    initial begin
        bus.L1I_read = 1'b0; bus.L1D_read = 1'b0; bus.L1D_write = 1'b0; bus.L2_resp = 1'b0;
        rst_req = 1'b1; rand_mode = 1'b0; hold_mode = 1'b0; fixed_lat = 3;

        i_act = 1'b1; d_act = 1'b1; d_wr = 1'b1;
        step();
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_outs", {bus.L2_read, bus.L2_write, bus.arbiter_fsm_sel, bus.L1I_resp, bus.L1D_resp}, 5'b0);
        step();
        rst_req = 1'b0;
        hold_mode = 1'b1;
        run(30);
        check("alt_grants_i", m_ig, 3);
        check("alt_grants_d", m_dg, 2);

        do_reset();
        fixed_lat = 3;
        i_act = 1'b1;
        run(12);
        check("t2_read_cycles", n_rd, 4);
        check("t2_iresp", n_ir, 1);
        check("t2_dresp", n_dr, 0);
`ifdef ARBITER_STATS_EN
        check("t2_i_grants", i_grants, sat(m_ig));
        check("t2_d_grants", d_grants, sat(m_dg));
`endif

        do_reset();
        fixed_lat = 0;
        i_act = 1'b1; d_act = 1'b1; d_wr = 1'b0;
        run(10);
        check("t4_read_cycles", n_rd, 2);
        check("t4_iresp", n_ir, 1);
        check("t4_dresp", n_dr, 1);
`ifdef ARBITER_STATS_EN
        check("t4_conflicts", conflicts, 1);
`endif

        do_reset();
        fixed_lat = 20;
        d_act = 1'b1; d_wr = 1'b1;
        run(3);
        d_act = 1'b0;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        run(3);
        @(negedge clk);
        check("t5_write_dropped", bus.L2_write, 1'b0);
        check("t5_write_cycles", n_wr, 3);
        check("t5_dresp", n_dr, 0);

        do_reset();
        rand_mode = 1'b1;
        run(3000);
        rand_mode = 1'b0;
        run(40);
        check("queue_drained", gq.size(), 0);
        check("model_idle", m_busy, 1'b0);
`ifdef ARBITER_STATS_EN
        check("rand_i_grants", i_grants, sat(m_ig));
        check("rand_d_grants", d_grants, sat(m_dg));
        check("rand_conflicts", conflicts, sat(m_cf));
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
